// File: rtl/nunchuk_bcd_converter_if.sv
// Sample/result bundle between the nunchuk register block and the digit decoders.
// master drives the sample side; slave is the converter.
interface nunchuk_bcd_converter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_value;
  logic                  in_z;
  logic                  in_c;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   digits;
  logic                  z_out;
  logic                  c_out;
  logic                  busy;

  modport master (
    output in_valid, in_value, in_z, in_c,
    input  in_ready, out_valid, digits, z_out, c_out, busy
  );

  modport slave (
    input  in_valid, in_value, in_z, in_c,
    output in_ready, out_valid, digits, z_out, c_out, busy
  );
endinterface

// File: rtl/nunchuk_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle,
// with registered digit codes and optional leading-zero blanking.
module nunchuk_bcd_converter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nunchuk_bcd_converter_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_hold_q, z_hold_d;
  logic               c_hold_q, c_hold_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               z_out_q, z_out_d;
  logic               c_out_q, c_out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   bcd_corr_c;
  logic [BCD_W-1:0]   bcd_shift_c;

  // Replace zero digits above the first nonzero one with the blank code; ones digit always shown.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] raw);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = raw;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (raw[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  // Add-3 correction on every nibble >= 5, then shift the next binary MSB in.
  always_comb begin
    bcd_corr_c = bcd_sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
        bcd_corr_c[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift_c = (bcd_corr_c << 1) | BCD_W'(bin_sr_q[WIDTH-1]);
  end

  always_comb begin
    state_d     = state_q;
    bin_sr_d    = bin_sr_q;
    bcd_sr_d    = bcd_sr_q;
    cnt_d       = cnt_q;
    z_hold_d    = z_hold_q;
    c_hold_d    = c_hold_q;
    digits_d    = digits_q;
    z_out_d     = z_out_q;
    c_out_d     = c_out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          bin_sr_d = bus.in_value;
          bcd_sr_d = '0;
          cnt_d    = CNT_W'(WIDTH);
          z_hold_d = bus.in_z;
          c_hold_d = bus.in_c;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_sr_d = bin_sr_q << 1;
        bcd_sr_d = bcd_shift_c;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          digits_d    = BLANK_LZ ? blank_lz(bcd_shift_c) : bcd_shift_c;
          z_out_d     = z_hold_q;
          c_out_d     = c_hold_q;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      cnt_q       <= '0;
      z_hold_q    <= 1'b0;
      c_hold_q    <= 1'b0;
      digits_q    <= '1;
      z_out_q     <= 1'b0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_sr_q    <= bin_sr_d;
      bcd_sr_q    <= bcd_sr_d;
      cnt_q       <= cnt_d;
      z_hold_q    <= z_hold_d;
      c_hold_q    <= c_hold_d;
      digits_q    <= digits_d;
      z_out_q     <= z_out_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Ready is a pure function of state and reset so the source sees no path from in_valid.
  assign bus.in_ready  = rst_n && (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.digits    = digits_q;
  assign bus.z_out     = z_out_q;
  assign bus.c_out     = c_out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nunchuk_bcd_converter.sv
// Self-checking bench: randomized and directed samples against a decimal reference model,
// one DUT with leading-zero blanking and one without, sharing the same stimulus.
module tb_nunchuk_bcd_converter;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned BW = 4 * D;

  logic clk;
  logic rst_n;

  nunchuk_bcd_converter_if #(.WIDTH(W), .DIGITS(D)) bus  ();
  nunchuk_bcd_converter_if #(.WIDTH(W), .DIGITS(D)) bus2 ();

  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_value = bus.in_value;
  assign bus2.in_z     = bus.in_z;
  assign bus2.in_c     = bus.in_c;

  nunchuk_bcd_converter #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  nunchuk_bcd_converter #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1'b0)) dut_raw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits by plain division; blanked digits are those above the value's decimal length.
  function automatic logic [BW-1:0] ref_digits(input int v, input bit blank);
    logic [BW-1:0] r;
    int p;
    int nd;
    r  = '0;
    p  = 1;
    nd = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      if (i > 0 && v >= p) nd = i + 1;
      p = p * 10;
    end
    if (blank) begin
      for (int i = nd; i < D; i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  typedef struct {
    int v;
    bit z;
    bit c;
    int acc;
  } txn_t;

  txn_t          q[$];
  int            cyc      = 0;
  bit            rst_prev = 1'b1;
  logic [BW-1:0] exp_d    = '1;
  logic [BW-1:0] exp_raw  = '1;
  bit            exp_z    = 1'b0;
  bit            exp_c    = 1'b0;

  // Reference model observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    txn_t t;
    bit   exp_busy;
    cyc++;
    if (rst_prev) begin
      exp_d   = '1;
      exp_raw = '1;
      exp_z   = 1'b0;
      exp_c   = 1'b0;
    end
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        t = q.pop_front();
        check("latency", 32'(cyc - t.acc), 32'(W + 1));
        exp_d   = ref_digits(t.v, 1'b1);
        exp_raw = ref_digits(t.v, 1'b0);
        exp_z   = t.z;
        exp_c   = t.c;
      end
    end else if (q.size() > 0 && cyc >= q[0].acc + int'(W) + 1) begin
      check("missing_valid", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    check("digits", 32'(bus.digits), 32'(exp_d));
    check("raw_digits", 32'(bus2.digits), 32'(exp_raw));
    check("z_out", 32'(bus.z_out), 32'(exp_z));
    check("c_out", 32'(bus.c_out), 32'(exp_c));
    exp_busy = (q.size() > 0) && (cyc > q[0].acc);
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("in_ready", 32'(bus.in_ready), 32'(rst_n && !exp_busy));
    if (!rst_n) begin
      q.delete();
    end else if (bus.in_valid && !exp_busy) begin
      q.push_back('{v: int'(bus.in_value), z: bus.in_z, c: bus.in_c, acc: cyc});
    end
    rst_prev = !rst_n;
  end

  task automatic send(input int v, input bit z, input bit c, output int acc);
    bit ok;
    acc = -1;
    bus.in_valid = 1'b1;
    bus.in_value = W'(v);
    bus.in_z     = z;
    bus.in_c     = c;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res(input string tag, input logic [BW-1:0] exp, output int ov_cyc, output int bcnt);
    bit seen;
    seen   = 1'b0;
    bcnt   = 0;
    ov_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.busy === 1'b1) bcnt++;
      if (bus.out_valid === 1'b1) begin
        seen   = 1'b1;
        ov_cyc = cyc;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    else       check(tag, 32'(bus.digits), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int acc, acc2, ov, ov2, bc, nov;
    logic [BW-1:0] dir_exp [4];
    int            dir_val [4];
    dir_val = '{0, 7, 100, 10};
    dir_exp = '{12'hFF0, 12'hFF7, 12'h100, 12'hF10};

    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_z     = 1'b0;
    bus.in_c     = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_digits", 32'(bus.digits), 32'hFFF);
    @(posedge clk);
    #1;
    idle(5);

    send(255, 1'b1, 1'b0, acc);
    bus.in_valid = 1'b0;
    wait_res("d255", 12'h255, ov, bc);
    check("d255_latency", 32'(ov - acc), 32'(W + 1));
    check("d255_busy_len", 32'(bc), 32'(W));
    check("d255_z", 32'(bus.z_out), 32'd1);
    check("d255_c", 32'(bus.c_out), 32'd0);
    idle(2);

    for (int i = 0; i < 4; i++) begin
      send(dir_val[i], 1'b0, 1'b1, acc);
      bus.in_valid = 1'b0;
      wait_res("dir_blank", dir_exp[i], ov, bc);
      if (dir_val[i] == 7) check("raw7", 32'(bus2.digits), 32'h007);
      idle(1);
    end

    send(42, 1'b0, 1'b1, acc);
    send(199, 1'b1, 1'b1, acc2);
    bus.in_valid = 1'b0;
    check("b2b_accept", 32'(acc2 - acc), 32'(W + 1));
    check("b2b_first", 32'(bus.digits), 32'hF42);
    wait_res("b2b_second", 12'h199, ov2, bc);
    check("b2b_gap", 32'(ov2 - acc2), 32'(W + 1));
    idle(2);

    send(123, 1'b0, 1'b0, acc);
    idle(3);
    bus.in_valid = 1'b1;
    bus.in_value = W'(99);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_res("busy_ignore", 12'h123, ov, bc);
    check("busy_ignore_lat", 32'(ov - acc), 32'(W + 1));
    idle(2);

    send(200, 1'b1, 1'b1, acc);
    idle(3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mid_digits", 32'(bus.digits), 32'hFFF);
    check("rst_mid_z", 32'(bus.z_out), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    nov = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nov++;
    end
    check("rst_mid_no_valid", 32'(nov), 32'd0);
    @(posedge clk);
    #1;
    send(58, 1'b1, 1'b0, acc);
    bus.in_valid = 1'b0;
    wait_res("post_rst", 12'hF58, ov, bc);
    idle(2);

    for (int v = 0; v < (1 << W); v++) begin
      send(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      idle(int'($urandom_range(0, 2)));
    end
    idle(W + 6);
    check("drain", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
